// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit.
// Bit period comes from clock_divider_i; a received byte is held in data_o with a sticky ready_o.
module uart_rx (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        ack_i,
  input  logic        parity_bit_i,
  input  logic        parity_even_i,
  input  logic        serial_i,
  input  logic [15:0] clock_divider_i,
  output logic [7:0]  data_o,
  output logic        ready_o
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   shift_q;
  logic                parity_ok_q;
  logic [DATA_W-1:0]   data_q;
  logic                ready_q;
  logic                ack_q;

  logic [CNT_W-1:0]    bit_len_c;
  logic [CNT_W-1:0]    half_len_c;
  logic                tick_c;
  logic                parity_req_c;
  logic                accept_c;

  // Effective bit length N (0 and 1 both mean 1) and half-bit H (minimum 1)
  always_comb begin
    bit_len_c  = (clock_divider_i < CNT_W'(2)) ? CNT_W'(1) : clock_divider_i;
    half_len_c = bit_len_c >> 1;
    if (half_len_c == '0) begin
      half_len_c = CNT_W'(1);
    end
  end

  assign tick_c       = (cnt_q <= CNT_W'(1));
  assign parity_req_c = (^shift_q) ^ ~parity_even_i;
  assign accept_c     = (state_q == STOP) && tick_c && serial_i &&
                        (parity_ok_q || !parity_bit_i);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      parity_ok_q <= 1'b0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      // An ack seen on an accepting edge is consumed so it cannot clear the fresh byte
      ack_q <= ack_i & ~accept_c;
      if (accept_c) begin
        data_q  <= shift_q;
        ready_q <= 1'b1;
      end else if (ack_q) begin
        ready_q <= 1'b0;
      end

      if (state_q == IDLE) begin
        if (!serial_i) begin
          cnt_q   <= half_len_c;
          state_q <= START;
        end
      end else if (!tick_c) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        unique case (state_q)
          START: begin
            if (!serial_i) begin
              cnt_q   <= bit_len_c;
              idx_q   <= '0;
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end
          DATA: begin
            shift_q <= {serial_i, shift_q[DATA_W-1:1]};
            cnt_q   <= bit_len_c;
            idx_q   <= IDX_W'(idx_q + IDX_W'(1));
            if (idx_q == IDX_W'(DATA_W - 1)) begin
              state_q <= parity_bit_i ? PARITY : STOP;
            end
          end
          PARITY: begin
            parity_ok_q <= (serial_i == parity_req_c);
            cnt_q       <= bit_len_c;
            state_q     <= STOP;
          end
          STOP: begin
            // Return at mid stop bit so a following start edge is caught promptly
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign data_o  = data_q;
  assign ready_o = ready_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven serially, expected bytes queued,
// and a monitor pops and compares whenever the receiver presents a new byte.
module tb_uart_rx;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        ack_i;
  logic        parity_bit_i;
  logic        parity_even_i;
  logic        serial_i;
  logic [15:0] clock_divider_i;
  logic [7:0]  data_o;
  logic        ready_o;

  int          checks_total  = 0;
  int          checks_passed = 0;
  int          cyc           = 0;
  int          stop_cyc      = 0;
  int          n             = 2;
  logic [7:0]  sb[$];

  uart_rx dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .ack_i           (ack_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .serial_i        (serial_i),
    .clock_divider_i (clock_divider_i),
    .data_o          (data_o),
    .ready_o         (ready_o)
  );

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit par_of(input logic [7:0] b, input bit even);
    return even ? ^b : ~^b;
  endfunction

  function automatic int half_of(input int nn);
    return (nn / 2 < 1) ? 1 : nn / 2;
  endfunction

  // Monitor: a rising ready_o or a changed byte while ready_o is high is a new delivery
  initial begin
    logic       rdy_prev  = 1'b0;
    logic [7:0] data_prev = 8'h00;
    logic [7:0] exp;
    forever begin
      @(posedge clock_i);
      #1;
      if (!reset_i && ready_o && (!rdy_prev || data_o != data_prev)) begin
        if (sb.size() == 0) begin
          check("spurious_byte", 32'(data_o), 32'(data_prev));
        end else begin
          exp = sb.pop_front();
          check("rx_byte", 32'(data_o), 32'(exp));
          check("rx_latency", 32'(cyc - stop_cyc), 32'(half_of(n) + 1));
        end
      end
      rdy_prev  = ready_o;
      data_prev = data_o;
    end
  end

  task automatic drive_bit(input logic v);
    @(posedge clock_i);
    #1;
    serial_i = v;
    repeat (n - 1) @(posedge clock_i);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_en, input logic par_val,
                            input logic stop_val, input bit expect_ok);
    if (expect_ok) sb.push_back(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (par_en) drive_bit(par_val);
    @(posedge clock_i);
    #1;
    serial_i = stop_val;
    stop_cyc = cyc;
    repeat (n - 1) @(posedge clock_i);
    @(posedge clock_i);
    #1;
    serial_i = 1'b1;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clock_i);
    #1;
  endtask

  task automatic drain(input string tag);
    int budget = 200;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clock_i);
      budget--;
    end
    #2;
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_ack();
    @(posedge clock_i);
    #1;
    ack_i = 1'b1;
    @(posedge clock_i);
    #1;
    check("ack_edge_hold", 32'(ready_o), 32'd1);
    ack_i = 1'b0;
    @(posedge clock_i);
    #1;
    check("ack_clear", 32'(ready_o), 32'd0);
  endtask

  task automatic set_n(input int nn);
    n               = nn;
    clock_divider_i = 16'(nn);
  endtask

  initial begin
    reset_i       = 1'b1;
    ack_i         = 1'b0;
    parity_bit_i  = 1'b0;
    parity_even_i = 1'b1;
    serial_i      = 1'b1;
    set_n(2);
    idle(3);
    check("reset_data", 32'(data_o), 32'h00);
    check("reset_ready", 32'(ready_o), 32'd0);
    reset_i = 1'b0;
    idle(4);

    // N=2, no parity, single byte then ack latency
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    drain("drain_55");
    check("t1_data", 32'(data_o), 32'h55);
    check("t1_ready", 32'(ready_o), 32'd1);
    pulse_ack();

    // N=2, back-to-back with ack between
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    drain("drain_55b");
    pulse_ack();
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b1);
    drain("drain_aa");
    check("t2_data", 32'(data_o), 32'hAA);
    check("t2_ready", 32'(ready_o), 32'd1);
    pulse_ack();

    // N=16, even parity: good then bad parity bit
    set_n(16);
    parity_bit_i  = 1'b1;
    parity_even_i = 1'b1;
    idle(4);
    send_frame(8'h03, 1'b1, par_of(8'h03, 1'b1), 1'b1, 1'b1);
    drain("drain_03");
    check("t3_data", 32'(data_o), 32'h03);
    pulse_ack();
    send_frame(8'h03, 1'b1, ~par_of(8'h03, 1'b1), 1'b1, 1'b0);
    idle(40);
    check("t3_bad_par_ready", 32'(ready_o), 32'd0);
    check("t3_bad_par_data", 32'(data_o), 32'h03);

    // Odd parity accepted when the bit matches
    parity_even_i = 1'b0;
    idle(4);
    send_frame(8'h96, 1'b1, par_of(8'h96, 1'b0), 1'b1, 1'b1);
    drain("drain_96");
    check("t3_odd_data", 32'(data_o), 32'h96);
    pulse_ack();

    // Framing error: stop bit low
    parity_bit_i = 1'b0;
    idle(4);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(40);
    check("t4_ready", 32'(ready_o), 32'd0);
    check("t4_data", 32'(data_o), 32'h96);

    // One-clock glitch, then overrun without ack
    @(posedge clock_i);
    #1;
    serial_i = 1'b0;
    @(posedge clock_i);
    #1;
    serial_i = 1'b1;
    idle(40);
    check("t5_glitch_ready", 32'(ready_o), 32'd0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    drain("drain_22");
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
    drain("drain_11");
    check("t5_data", 32'(data_o), 32'h11);
    check("t5_ready", 32'(ready_o), 32'd1);

    // Reset mid-frame, then a clean frame
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    @(posedge clock_i);
    #3;
    reset_i = 1'b1;
    #1;
    check("t6_rst_data", 32'(data_o), 32'h00);
    check("t6_rst_ready", 32'(ready_o), 32'd0);
    serial_i = 1'b1;
    idle(2);
    reset_i = 1'b0;
    idle(4);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1);
    drain("drain_c3");
    check("t6_data", 32'(data_o), 32'hC3);
    check("t6_ready", 32'(ready_o), 32'd1);

    idle(4);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
